radix_stage_ctrl: RTL and testbench
===================================

Name: radix_stage_ctrl

Overview:
Sequencing controller for one radix-2 single-delay-feedback FFT stage: the FIFO/delay line, the butterfly, the twiddle ROM and the output mux.
- Counts accepted samples per frame and splits each frame into a fill half and a butterfly half of D = 2^(bram_addr_len-stageNum) samples.
- Issues delay-line write, butterfly-enable, twiddle-address and output-select strobes.
- Drains the stored lower-butterfly outputs on request.
- One instance sits beside each radix stage in the pipeline.

Parameters:
bram_addr_len, 13, log2 of FFT points per frame (8192).
stageNum, 1, stage index 1..bram_addr_len; sets half-span D = 2^(bram_addr_len-stageNum).
bram_tf_addr_len, 12, twiddle ROM address width; must equal bram_addr_len-stageNum (elaboration error otherwise). Port width TF_W = max(1, bram_tf_addr_len).
frame_cnt_len, 16, width of the frame counter.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
data_in_valid  in  1  upstream sample present this cycle.
flush  in  1  single-cycle pulse; request drain of stored lower outputs.
in_ready  out  1  stage accepts samples; sample accepted = data_in_valid & in_ready.
dly_wr_en  out  1  write the accepted sample into the delay line (fill half).
bf_en  out  1  combine the accepted sample with the delay-line head; emit y1; write y2 to the delay line.
dly_out_sel  out  1  output mux selects delay-line head (stored y2).
tf_addr  out  TF_W  twiddle ROM address, aligned with bf_en.
tf_rd_en  out  1  twiddle ROM read enable, equal to bf_en.
out_valid  out  1  stage output valid = bf_en | dly_out_sel.
frame_done  out  1  one-cycle pulse on the last butterfly sample of a frame.
frame_cnt  out  frame_cnt_len  completed frames; wraps modulo 2^frame_cnt_len.
busy  out  1  state != IDLE or pending set.
err_ovf  out  1  sticky; set when data_in_valid=1 while in_ready=0.

Behaviour:
- Synchronous active-high reset on rst. All outputs 0 except in_ready=1. State IDLE, counter 0, pending 0, err_ovf cleared.
- All strobes are registered: they assert in the cycle after the accepting edge (latency 1). tf_addr is valid in the same cycle as bf_en. The datapath compensates for the 1-cycle ROM latency.
- Internal cnt is bram_addr_len bits wide. Phase bit = cnt[bram_addr_len-stageNum]: 0 means fill, 1 means butterfly. Local index k = cnt mod D. cnt increments only on an accepted sample and wraps to 0 after 2^(bram_addr_len-stageNum+1)... all counting is modulo 2D within a frame.
- States:
  - IDLE: in_ready=1. An accepted sample goes to FILL; its dly_wr_en is asserted.
  - FILL: per accepted sample, dly_wr_en=1. If pending=1, dly_out_sel=1 on the same sample (the previous frame's y2 is emitted while overwritten). After the D-th sample, go to BFLY.
  - BFLY: per accepted sample, bf_en=1, tf_rd_en=1, tf_addr=k (k=0..D-1). On the D-th sample: frame_done=1, frame_cnt+1, pending set, next state FILL with cnt=0.
  - DRAIN: in_ready=0. Emits dly_out_sel=1 on D consecutive cycles, then clears pending and goes to IDLE.
- flush is honoured only in FILL with cnt=0 and pending=1, and only when no sample is accepted that same cycle. In that case go to DRAIN next cycle. If flush and an accepted sample coincide, the sample wins and flush is ignored. flush in any other state is ignored.
- Gaps in data_in_valid freeze the counter and all strobes; no timeout.
- When stageNum = bram_addr_len (D=1): fill and butterfly alternate every sample; tf_addr is held at 0.
- err_ovf sets on data_in_valid & ~in_ready. That sample is dropped and not counted. err_ovf is cleared only by rst.
- rst mid-frame or mid-drain: return to the reset state on the next edge. The partial frame and pending data are discarded. frame_cnt is cleared.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, FILL, BFLY, DRAIN);
  - function for D from bram_addr_len and stageNum;
  - TF_W computation;
  - float_len=32 for sibling datapath blocks.
- One natural sub-module, stage_sample_counter: modulo-2D counter with enable. It outputs phase, k and last-of-half flag. The FSM and strobe registers stay in the top.

Test Plan:
1. Reset check: assert rst 2 cycles, then release. Required: all outputs 0, in_ready=1, busy=0, err_ovf=0.
2. Single frame, bram_addr_len=3, stageNum=1 (D=4), 8 consecutive valid samples from cycle 0. Required:
   - dly_wr_en in cycles 1-4;
   - bf_en and tf_rd_en in cycles 5-8, with tf_addr 0,1,2,3;
   - frame_done only in cycle 8; frame_cnt=1.
3. Back-to-back frames: 16 consecutive valid samples. Required:
   - dly_out_sel in cycles 9-12;
   - out_valid continuously high in cycles 5-16;
   - frame_cnt=2.
4. Flush after frame 1: pulse flush in cycle 10 with data_in_valid=0. Required:
   - in_ready=0 in cycles 11-14;
   - dly_out_sel in cycles 11-14;
   - IDLE at cycle 15 with busy=0.
   - Additionally, data_in_valid=1 in cycle 12 sets err_ovf=1 and cnt is unchanged.
5. Gapped input: valid on alternate cycles for 8 samples. Required: 4 dly_wr_en pulses, then 4 bf_en pulses with tf_addr 0..3, each 1 cycle after its accepted sample; no strobe in gap cycles.
6. Edge configuration and reset:
   - stageNum=3 (D=1), 4 samples: dly_wr_en, bf_en, dly_wr_en+dly_out_sel, bf_en; tf_addr always 0.
   - rst asserted mid-BFLY: next cycle all outputs at reset values and frame_cnt=0.

Source files
------------

// File: rtl/radix_stage_ctrl_pkg.sv
// Shared constants and helpers for the radix-2 SDF stage controller and its sibling datapath blocks.
package radix_stage_ctrl_pkg;

   localparam int unsigned float_len = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_BFLY  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   // Half-span D: number of samples in each fill or butterfly half of a frame.
   function automatic int unsigned half_span(input int unsigned addr_len, input int unsigned stage);
      return 32'(1) << (addr_len - stage);
   endfunction

   // Twiddle port width; a zero-width ROM address still needs a one-bit port.
   function automatic int unsigned tf_width(input int unsigned tf_len);
      return (tf_len > 0) ? tf_len : 32'(1);
   endfunction

endpackage

// File: rtl/radix_stage_ctrl_sample_counter.sv
// Modulo-2D sample counter: phase bit, in-half index k and last-of-half flag.
module stage_sample_counter
   import radix_stage_ctrl_pkg::*;
#(
   parameter int unsigned LOG2D = 12,
   parameter int unsigned TF_W  = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   output logic            phase,
   output logic [TF_W-1:0] k,
   output logic            last
);

   localparam int unsigned CNT_W = LOG2D + 1;

   logic [CNT_W-1:0] cnt;

   // Natural binary wrap of LOG2D+1 bits gives the modulo-2D count.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (en)
         cnt <= cnt + CNT_W'(1);
   end

   assign phase = cnt[LOG2D];

   generate
      if (LOG2D == 0) begin : g_unit
         assign k    = '0;
         assign last = 1'b1;
      end else begin : g_span
         assign k    = TF_W'(cnt[LOG2D-1:0]);
         assign last = &cnt[LOG2D-1:0];
      end
   endgenerate

endmodule

// File: rtl/radix_stage_ctrl.sv
// Sequencing controller for one radix-2 single-delay-feedback FFT stage.
module radix_stage_ctrl
   import radix_stage_ctrl_pkg::*;
#(
   parameter int unsigned bram_addr_len    = 13,
   parameter int unsigned stageNum         = 1,
   parameter int unsigned bram_tf_addr_len = 12,
   parameter int unsigned frame_cnt_len    = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      data_in_valid,
   input  logic                                      flush,
   output logic                                      in_ready,
   output logic                                      dly_wr_en,
   output logic                                      bf_en,
   output logic                                      dly_out_sel,
   output logic [tf_width(bram_tf_addr_len)-1:0]     tf_addr,
   output logic                                      tf_rd_en,
   output logic                                      out_valid,
   output logic                                      frame_done,
   output logic [frame_cnt_len-1:0]                  frame_cnt,
   output logic                                      busy,
   output logic                                      err_ovf
);

   localparam int unsigned LOG2D = bram_addr_len - stageNum;
   localparam int unsigned D     = half_span(bram_addr_len, stageNum);
   localparam int unsigned TF_W  = tf_width(bram_tf_addr_len);
   localparam int unsigned CNT_W = LOG2D + 1;

   generate
      if (stageNum < 1 || stageNum > bram_addr_len ||
          bram_tf_addr_len != bram_addr_len - stageNum) begin : g_cfg_err
         $error("radix_stage_ctrl: bram_tf_addr_len must equal bram_addr_len-stageNum, stageNum in 1..bram_addr_len");
      end
   endgenerate

   logic                     accept_c;
   logic                     cnt_en;
   logic                     phase;
   logic [TF_W-1:0]          k;
   logic                     last;
   logic                     at_start_c;

   logic [1:0]               state, state_nxt;
   logic [CNT_W-1:0]         dcnt, dcnt_nxt;
   logic                     pending, pending_nxt;
   logic                     ready_nxt, wr_nxt, bf_nxt, sel_nxt, ov_nxt, done_nxt, busy_nxt, err_nxt;
   logic [TF_W-1:0]          tf_nxt;
   logic [frame_cnt_len-1:0] frame_cnt_nxt;

   assign accept_c   = data_in_valid & in_ready;
   assign at_start_c = ~phase & (k == '0);
   assign tf_rd_en   = bf_en;

   stage_sample_counter #(
      .LOG2D (LOG2D),
      .TF_W  (TF_W)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (cnt_en),
      .phase (phase),
      .k     (k),
      .last  (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         dcnt        <= '0;
         pending     <= 1'b0;
         in_ready    <= 1'b1;
         dly_wr_en   <= 1'b0;
         bf_en       <= 1'b0;
         dly_out_sel <= 1'b0;
         tf_addr     <= '0;
         out_valid   <= 1'b0;
         frame_done  <= 1'b0;
         frame_cnt   <= '0;
         busy        <= 1'b0;
         err_ovf     <= 1'b0;
      end else begin
         state       <= state_nxt;
         dcnt        <= dcnt_nxt;
         pending     <= pending_nxt;
         in_ready    <= ready_nxt;
         dly_wr_en   <= wr_nxt;
         bf_en       <= bf_nxt;
         dly_out_sel <= sel_nxt;
         tf_addr     <= tf_nxt;
         out_valid   <= ov_nxt;
         frame_done  <= done_nxt;
         frame_cnt   <= frame_cnt_nxt;
         busy        <= busy_nxt;
         err_ovf     <= err_nxt;
      end
   end

   // Next state and next registered strobes; strobes describe the sample accepted this edge.
   always_comb begin
      state_nxt     = state;
      dcnt_nxt      = dcnt;
      pending_nxt   = pending;
      frame_cnt_nxt = frame_cnt;
      cnt_en        = 1'b0;
      wr_nxt        = 1'b0;
      bf_nxt        = 1'b0;
      sel_nxt       = 1'b0;
      done_nxt      = 1'b0;
      tf_nxt        = '0;
      err_nxt       = err_ovf | (data_in_valid & ~in_ready);

      case (state)
         ST_IDLE, ST_FILL: begin
            if (accept_c) begin
               cnt_en  = 1'b1;
               wr_nxt  = 1'b1;
               sel_nxt = pending;
               if (last) begin
                  state_nxt   = ST_BFLY;
                  pending_nxt = 1'b0;
               end else begin
                  state_nxt = ST_FILL;
               end
            end else if (state == ST_FILL && flush && pending && at_start_c) begin
               state_nxt = ST_DRAIN;
               dcnt_nxt  = '0;
               sel_nxt   = 1'b1;
            end
         end
         ST_BFLY: begin
            if (accept_c) begin
               cnt_en = 1'b1;
               bf_nxt = 1'b1;
               tf_nxt = k;
               if (last) begin
                  done_nxt      = 1'b1;
                  frame_cnt_nxt = frame_cnt + frame_cnt_len'(1);
                  pending_nxt   = 1'b1;
                  state_nxt     = ST_FILL;
               end
            end
         end
         ST_DRAIN: begin
            if (dcnt == CNT_W'(D - 1)) begin
               state_nxt   = ST_IDLE;
               pending_nxt = 1'b0;
            end else begin
               dcnt_nxt = dcnt + CNT_W'(1);
               sel_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      ready_nxt = (state_nxt != ST_DRAIN);
      ov_nxt    = bf_nxt | sel_nxt;
      busy_nxt  = (state_nxt != ST_IDLE) | pending_nxt;
   end

endmodule

// File: tb/tb_radix_stage_ctrl.sv
// Bench for radix_stage_ctrl: D=4 and D=1 instances against a sample-position reference model.
module tb_radix_stage_ctrl;

   localparam int DA = 4;
   localparam int DB = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, va, fa, vb, fb;

   logic        ra, wa, ba, sa, tra, ova, da, bua, ea;
   logic [1:0]  ta;
   logic [15:0] fca;
   logic        rb, wb, bb, sb, trb, ovb, db, bub, eb;
   logic [0:0]  tb_;
   logic [15:0] fcb;

   radix_stage_ctrl #(.bram_addr_len(3), .stageNum(1), .bram_tf_addr_len(2), .frame_cnt_len(16)) dut_a (
      .clk(clk), .rst(rst), .data_in_valid(va), .flush(fa), .in_ready(ra), .dly_wr_en(wa),
      .bf_en(ba), .dly_out_sel(sa), .tf_addr(ta), .tf_rd_en(tra), .out_valid(ova),
      .frame_done(da), .frame_cnt(fca), .busy(bua), .err_ovf(ea));

   radix_stage_ctrl #(.bram_addr_len(3), .stageNum(3), .bram_tf_addr_len(0), .frame_cnt_len(16)) dut_b (
      .clk(clk), .rst(rst), .data_in_valid(vb), .flush(fb), .in_ready(rb), .dly_wr_en(wb),
      .bf_en(bb), .dly_out_sel(sb), .tf_addr(tb_), .tf_rd_en(trb), .out_valid(ovb),
      .frame_done(db), .frame_cnt(fcb), .busy(bub), .err_ovf(eb));

   // Model tracks position within the 2D-sample frame, not controller states.
   typedef struct {
      int pos; bit pending; bit idle; int drain; int frames; bit err;
      bit ready; bit wr; bit bf; bit sel; bit done; int tf;
   } mdl_t;

   mdl_t ma, mb;
   int   n_cmp = 0, n_fail = 0, cyc = 0;
   bit   chk_on = 1'b0;

   function automatic mdl_t mdl_next(input mdl_t m0, input int d, input bit r, input bit v, input bit fl);
      mdl_t m = m0;
      if (r) begin
         m = '{pos:0, pending:0, idle:1, drain:0, frames:0, err:0,
               ready:1, wr:0, bf:0, sel:0, done:0, tf:0};
         return m;
      end
      m.err = m.err | (v & ~m.ready);
      m.wr = 0; m.bf = 0; m.sel = 0; m.done = 0; m.tf = 0;
      if (m.drain > 0) begin
         m.drain--;
         if (m.drain > 0) m.sel = 1;
         else begin m.pending = 0; m.idle = 1; end
      end else if (v) begin
         m.idle = 0;
         if (m.pos < d) begin m.wr = 1; m.sel = m.pending; end
         else begin m.bf = 1; m.tf = m.pos - d; end
         m.pos++;
         if (m.pos == d) m.pending = 0;
         if (m.pos == 2 * d) begin m.pos = 0; m.done = 1; m.frames++; m.pending = 1; end
      end else if (fl && m.pending && m.pos == 0) begin
         m.drain = d; m.sel = 1;
      end
      m.ready = (m.drain == 0);
      return m;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("a.in_ready",    32'(ra),  32'(ma.ready));
         chk("a.dly_wr_en",   32'(wa),  32'(ma.wr));
         chk("a.bf_en",       32'(ba),  32'(ma.bf));
         chk("a.tf_rd_en",    32'(tra), 32'(ma.bf));
         chk("a.dly_out_sel", 32'(sa),  32'(ma.sel));
         chk("a.tf_addr",     32'(ta),  32'(ma.tf));
         chk("a.out_valid",   32'(ova), 32'(ma.bf | ma.sel));
         chk("a.frame_done",  32'(da),  32'(ma.done));
         chk("a.frame_cnt",   32'(fca), 32'(ma.frames % 65536));
         chk("a.busy",        32'(bua), 32'(!ma.idle || ma.pending || ma.drain > 0));
         chk("a.err_ovf",     32'(ea),  32'(ma.err));
         chk("b.in_ready",    32'(rb),  32'(mb.ready));
         chk("b.dly_wr_en",   32'(wb),  32'(mb.wr));
         chk("b.bf_en",       32'(bb),  32'(mb.bf));
         chk("b.tf_rd_en",    32'(trb), 32'(mb.bf));
         chk("b.dly_out_sel", 32'(sb),  32'(mb.sel));
         chk("b.tf_addr",     32'(tb_), 32'(mb.tf));
         chk("b.out_valid",   32'(ovb), 32'(mb.bf | mb.sel));
         chk("b.frame_done",  32'(db),  32'(mb.done));
         chk("b.frame_cnt",   32'(fcb), 32'(mb.frames % 65536));
         chk("b.busy",        32'(bub), 32'(!mb.idle || mb.pending || mb.drain > 0));
         chk("b.err_ovf",     32'(eb),  32'(mb.err));
      end
   end

   // One clock: models advance on the edge with the same inputs the DUTs sample.
   task automatic tick();
      @(posedge clk);
      ma = mdl_next(ma, DA, rst, va, fa);
      mb = mdl_next(mb, DB, rst, vb, fb);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1; va = 0; fa = 0; vb = 0; fb = 0;
      tick();
      chk_on = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      int c, nw, nb, blk_p;
      int exp_w[4], exp_b[4], exp_s[4];
      exp_w = '{1, 0, 1, 0};
      exp_b = '{0, 1, 0, 1};
      exp_s = '{0, 0, 1, 0};
      rst = 1; va = 0; fa = 0; vb = 0; fb = 0;
      ma = mdl_next(ma, DA, 1'b1, 1'b0, 1'b0);
      mb = mdl_next(mb, DB, 1'b1, 1'b0, 1'b0);
      @(negedge clk);

      // Reset values
      do_reset();
      tick();
      chk("t1.in_ready", 32'(ra), 32'd1);
      chk("t1.busy", 32'(bua), 32'd0);
      chk("t1.err_ovf", 32'(ea), 32'd0);
      chk("t1.out_valid", 32'(ova), 32'd0);

      // Single frame, D=4
      do_reset();
      for (int i = 0; i < 8; i++) begin
         va = 1; tick(); c = i + 1;
         chk("t2.dly_wr_en", 32'(wa), 32'(c <= 4));
         chk("t2.bf_en", 32'(ba), 32'(c >= 5));
         if (c >= 5) chk("t2.tf_addr", 32'(ta), 32'(c - 5));
         chk("t2.frame_done", 32'(da), 32'(c == 8));
      end
      va = 0;
      chk("t2.frame_cnt", 32'(fca), 32'd1);

      // Back-to-back frames
      do_reset();
      for (int i = 0; i < 16; i++) begin
         va = 1; tick(); c = i + 1;
         chk("t3.dly_out_sel", 32'(sa), 32'(c >= 9 && c <= 12));
         if (c >= 5) chk("t3.out_valid", 32'(ova), 32'd1);
      end
      va = 0;
      chk("t3.frame_cnt", 32'(fca), 32'd2);

      // Flush drain with an overflow attempt during the drain
      do_reset();
      for (int i = 0; i < 15; i++) begin
         va = (i < 8 || i == 12); fa = (i == 10);
         tick(); c = i + 1;
         if (c >= 11 && c <= 14) begin
            chk("t4.in_ready", 32'(ra), 32'd0);
            chk("t4.dly_out_sel", 32'(sa), 32'd1);
         end
         if (c == 13) chk("t4.err_ovf", 32'(ea), 32'd1);
         if (c == 15) begin
            chk("t4.busy", 32'(bua), 32'd0);
            chk("t4.in_ready", 32'(ra), 32'd1);
         end
      end
      va = 0; fa = 0;
      for (int i = 0; i < 8; i++) begin va = 1; tick(); end
      va = 0;
      chk("t4.frame_cnt", 32'(fca), 32'd2);

      // Gapped input
      do_reset();
      nw = 0; nb = 0;
      for (int i = 0; i < 16; i++) begin
         va = (i % 2 == 0); tick(); c = i + 1;
         nw += int'(wa); nb += int'(ba);
         if (c % 2 == 0) chk("t5.gap_strobe", 32'(wa | ba | sa), 32'd0);
         if (ba) chk("t5.tf_addr", 32'(ta), 32'(nb - 1));
      end
      va = 0;
      chk("t5.wr_pulses", 32'(nw), 32'd4);
      chk("t5.bf_pulses", 32'(nb), 32'd4);

      // D=1 alternation
      do_reset();
      for (int i = 0; i < 4; i++) begin
         vb = 1; tick();
         chk("t6.dly_wr_en", 32'(wb), 32'(exp_w[i]));
         chk("t6.bf_en", 32'(bb), 32'(exp_b[i]));
         chk("t6.dly_out_sel", 32'(sb), 32'(exp_s[i]));
         chk("t6.tf_addr", 32'(tb_), 32'd0);
      end
      vb = 0;

      // Reset mid-butterfly of the second frame
      do_reset();
      for (int i = 0; i < 14; i++) begin va = 1; tick(); end
      chk("t6.pre_frame_cnt", 32'(fca), 32'd1);
      va = 0; rst = 1; tick(); rst = 0;
      chk("t6.rst_frame_cnt", 32'(fca), 32'd0);
      chk("t6.rst_in_ready", 32'(ra), 32'd1);
      chk("t6.rst_bf_en", 32'(ba), 32'd0);
      chk("t6.rst_busy", 32'(bua), 32'd0);

      // Randomized traffic with bursty and sparse phases
      blk_p = 70;
      for (int i = 0; i < 4000; i++) begin
         if (i % 64 == 0) blk_p = (($urandom_range(0, 2) == 0) ? 25 : (($urandom_range(0, 1) == 0) ? 70 : 100));
         va  = ($urandom_range(0, 99) < blk_p);
         vb  = ($urandom_range(0, 99) < blk_p);
         fa  = ($urandom_range(0, 3) == 0);
         fb  = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 999) == 0);
         tick();
      end
      rst = 0; va = 0; vb = 0; fa = 0; fb = 0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
